rs232receive: RTL

Asynchronous RS-232 serial receiver: the downstream partner of the team's rs232 transmitter, consuming the same 8N1 line format at the same baud divisor on clock_27mhz. It recovers start/data/stop bits by mid-bit majority sampling and presents each received byte on a parallel port with a ready/ack handshake. It also flags framing errors and overruns. It feeds command decoding logic on the FPGA side.

---
 rtl/rs232receive_if.sv | 19 +
 rtl/rs232receive.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rs232receive_if.sv
// Parallel-side handshake of the RS-232 receiver: received byte, ready/ack, status pulses.
interface rs232receive_if;
  logic [7:0] data;
  logic       data_ready;
  logic       data_ack;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  modport master (
    output data, data_ready, framing_error, overrun, busy,
    input  data_ack
  );

  modport slave (
    input  data, data_ready, framing_error, overrun, busy,
    output data_ack
  );
endinterface

// File: rtl/rs232receive.sv
// 8N1 RS-232 receiver: 2-flop synchroniser, 3-sample majority vote, mid-bit sampling,
// ready/ack byte handoff with framing-error and overrun pulses.
module rs232receive #(
  parameter int unsigned DIVISOR = 234
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rxd,
  rs232receive_if.master  rx
);

  localparam int unsigned HALF = DIVISOR / 2;
  localparam int unsigned CW   = $clog2(DIVISOR);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitMark} state_e;

  state_e          state_q, state_d;
  logic            rxd_meta, rxs;
  logic [2:0]      hist;
  logic            maj;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            busy_q;
  logic            count_end, half_end;

  assign maj       = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign count_end = (count_q == CW'(DIVISOR - 1));
  assign half_end  = (count_q == CW'(HALF - 1));

  // Synchroniser and history reset to mark so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
      hist     <= 3'b111;
    end else begin
      rxd_meta <= rxd;
      rxs      <= rxd_meta;
      hist     <= {hist[1:0], rxs};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (!rxs) state_d = StStart;
      StStart:    if (half_end) state_d = maj ? StIdle : StData;
      StData:     if (count_end && (bit_q == 3'd7)) state_d = StStop;
      StStop:     if (count_end) state_d = maj ? StIdle : StWaitMark;
      StWaitMark: if (rxs) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = ready_q & ~rx.data_ack;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        count_d = '0;
        bit_d   = '0;
      end
      StStart: begin
        count_d = half_end ? '0 : count_q + 1'b1;
        bit_d   = '0;
      end
      StData: begin
        if (count_end) begin
          count_d = '0;
          shift_d = {maj, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      StStop: begin
        if (count_end) begin
          count_d = '0;
          if (maj) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            // An ack landing on the load cycle consumes the old byte, so no overrun.
            ovr_d   = ready_q & ~rx.data_ack;
          end else begin
            ferr_d  = 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      StWaitMark: count_d = '0;
      default:    count_d = '0;
    endcase
  end

  assign rx.data          = data_q;
  assign rx.data_ready    = ready_q;
  assign rx.framing_error = ferr_q;
  assign rx.overrun       = ovr_q;
  assign rx.busy          = busy_q;

endmodule
